// File: rtl/axil2sreg_pkg.sv
// Shared definitions for the AXI4-Lite to register-bus bridge:
// FSM encoding, AXI response codes and access-legality helpers.
package axil2sreg_pkg;

   // Bridge FSM states
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_WSTB  = 3'd1,
      ST_WRSP  = 3'd2,
      ST_RSTB  = 3'd3,
      ST_RWAIT = 3'd4,
      ST_RRSP  = 3'd5
   } state_t;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [3:0] FULL_STRB   = 4'hF;

   // A register access must be word aligned.
   function automatic logic misaligned(input logic [1:0] addr_lsb);
      return (addr_lsb != 2'b00);
   endfunction

   // Writes must be aligned and cover the whole 32-bit word; the register
   // bus has no byte enables, so partial writes are rejected.
   function automatic logic write_illegal(input logic [1:0] addr_lsb,
                                          input logic [3:0] strb);
      return misaligned(addr_lsb) || (strb != FULL_STRB);
   endfunction

endpackage

// File: rtl/axil2sreg.sv
// AXI4-Lite slave to simple synchronous register bus bridge.
// AW, W and AR are captured into holding registers; a single FSM then
// serialises one register access at a time and returns the AXI response.
// All outputs are registered from the computed next state.
module axil2sreg
   import axil2sreg_pkg::*;
#(
   parameter int ADDR_W = 18,
   parameter int RD_LAT = 0
)(
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       s_awaddr,
   input  logic              s_awvalid,
   output logic              s_awready,
   input  logic [31:0]       s_wdata,
   input  logic [3:0]        s_wstrb,
   input  logic              s_wvalid,
   output logic              s_wready,
   output logic [1:0]        s_bresp,
   output logic              s_bvalid,
   input  logic              s_bready,
   input  logic [31:0]       s_araddr,
   input  logic              s_arvalid,
   output logic              s_arready,
   output logic [31:0]       s_rdata,
   output logic [1:0]        s_rresp,
   output logic              s_rvalid,
   input  logic              s_rready,
   output logic              reg_en,
   output logic              reg_wen,
   output logic [ADDR_W-1:0] reg_addr,
   output logic [31:0]       reg_wdata,
   input  logic [31:0]       reg_rdata
);

   // Wait-counter reload: RWAIT lasts RD_LAT cycles, counting down to 0.
   localparam logic [1:0] LAT_LOAD = (RD_LAT > 0) ? 2'(RD_LAT - 1) : 2'd0;

   state_t state, state_nx;

   logic              aw_held, aw_held_nx;
   logic              w_held, w_held_nx;
   logic              ar_held, ar_held_nx;
   logic [ADDR_W-1:0] aw_addr, aw_addr_nx;
   logic [ADDR_W-1:0] ar_addr, ar_addr_nx;
   logic [31:0]       w_data, w_data_nx;
   logic [3:0]        w_strb, w_strb_nx;
   logic              last_wr, last_wr_nx;
   logic [1:0]        lat_cnt, lat_cnt_nx;

   logic              awready_nx, wready_nx, arready_nx;
   logic              bvalid_nx, rvalid_nx;
   logic [1:0]        bresp_nx, rresp_nx;
   logic [31:0]       rdata_nx;
   logic              reg_en_nx, reg_wen_nx;
   logic [ADDR_W-1:0] reg_addr_nx;
   logic [31:0]       reg_wdata_nx;

   logic              aw_hs, w_hs, ar_hs;
   logic              wr_rdy, rd_rdy, serve_wr, serve_rd;

   // Upper AXI address bits are deliberately ignored (address truncation).
   logic              unused_addr_bits;
   assign unused_addr_bits = ^{s_awaddr, s_araddr};

   assign aw_hs = s_awvalid & s_awready;
   assign w_hs  = s_wvalid  & s_wready;
   assign ar_hs = s_arvalid & s_arready;

   // Arbitration on held channels only: alternate when both are pending.
   assign wr_rdy   = aw_held & w_held;
   assign rd_rdy   = ar_held;
   assign serve_wr = wr_rdy & (~rd_rdy | ~last_wr);
   assign serve_rd = rd_rdy & ~serve_wr;

   // Next-state, channel capture and output computation.
   always_comb begin
      state_nx     = state;
      aw_held_nx   = aw_held;
      w_held_nx    = w_held;
      ar_held_nx   = ar_held;
      aw_addr_nx   = aw_addr;
      ar_addr_nx   = ar_addr;
      w_data_nx    = w_data;
      w_strb_nx    = w_strb;
      last_wr_nx   = last_wr;
      lat_cnt_nx   = lat_cnt;
      bvalid_nx    = s_bvalid;
      bresp_nx     = s_bresp;
      rvalid_nx    = s_rvalid;
      rresp_nx     = s_rresp;
      rdata_nx     = s_rdata;
      reg_en_nx    = 1'b0;
      reg_wen_nx   = 1'b0;
      reg_addr_nx  = reg_addr;
      reg_wdata_nx = reg_wdata;

      if (aw_hs) begin
         aw_held_nx = 1'b1;
         aw_addr_nx = s_awaddr[ADDR_W-1:0];
      end else begin
         aw_held_nx = aw_held;
      end

      if (w_hs) begin
         w_held_nx = 1'b1;
         w_data_nx = s_wdata;
         w_strb_nx = s_wstrb;
      end else begin
         w_held_nx = w_held;
      end

      if (ar_hs) begin
         ar_held_nx = 1'b1;
         ar_addr_nx = s_araddr[ADDR_W-1:0];
      end else begin
         ar_held_nx = ar_held;
      end

      case (state)
         ST_IDLE: begin
            if (serve_wr) begin
               if (write_illegal(aw_addr[1:0], w_strb)) begin
                  state_nx  = ST_WRSP;
                  bresp_nx  = RESP_SLVERR;
                  bvalid_nx = 1'b1;
               end else begin
                  state_nx     = ST_WSTB;
                  reg_en_nx    = 1'b1;
                  reg_wen_nx   = 1'b1;
                  reg_addr_nx  = aw_addr;
                  reg_wdata_nx = w_data;
               end
            end else if (serve_rd) begin
               if (misaligned(ar_addr[1:0])) begin
                  state_nx  = ST_RRSP;
                  rresp_nx  = RESP_SLVERR;
                  rdata_nx  = 32'h0000_0000;
                  rvalid_nx = 1'b1;
               end else begin
                  state_nx    = ST_RSTB;
                  reg_en_nx   = 1'b1;
                  reg_addr_nx = ar_addr;
               end
            end else begin
               state_nx = ST_IDLE;
            end
         end
         ST_WSTB: begin
            state_nx  = ST_WRSP;
            bresp_nx  = RESP_OKAY;
            bvalid_nx = 1'b1;
         end
         ST_WRSP: begin
            if (s_bready) begin
               state_nx   = ST_IDLE;
               bvalid_nx  = 1'b0;
               aw_held_nx = 1'b0;
               w_held_nx  = 1'b0;
               last_wr_nx = 1'b1;
            end else begin
               state_nx = ST_WRSP;
            end
         end
         ST_RSTB: begin
            if (RD_LAT == 0) begin
               state_nx  = ST_RRSP;
               rdata_nx  = reg_rdata;
               rresp_nx  = RESP_OKAY;
               rvalid_nx = 1'b1;
            end else begin
               state_nx   = ST_RWAIT;
               lat_cnt_nx = LAT_LOAD;
            end
         end
         ST_RWAIT: begin
            if (lat_cnt == 2'd0) begin
               state_nx  = ST_RRSP;
               rdata_nx  = reg_rdata;
               rresp_nx  = RESP_OKAY;
               rvalid_nx = 1'b1;
            end else begin
               lat_cnt_nx = lat_cnt - 2'd1;
            end
         end
         ST_RRSP: begin
            if (s_rready) begin
               state_nx   = ST_IDLE;
               rvalid_nx  = 1'b0;
               ar_held_nx = 1'b0;
               last_wr_nx = 1'b0;
            end else begin
               state_nx = ST_RRSP;
            end
         end
         default: begin
            state_nx = ST_IDLE;
         end
      endcase

      awready_nx = (state_nx == ST_IDLE) & ~aw_held_nx;
      wready_nx  = (state_nx == ST_IDLE) & ~w_held_nx;
      arready_nx = (state_nx == ST_IDLE) & ~ar_held_nx;
   end

   // State, holding registers and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         aw_held   <= 1'b0;
         w_held    <= 1'b0;
         ar_held   <= 1'b0;
         aw_addr   <= '0;
         ar_addr   <= '0;
         w_data    <= 32'h0000_0000;
         w_strb    <= 4'h0;
         last_wr   <= 1'b0;
         lat_cnt   <= 2'd0;
         s_awready <= 1'b0;
         s_wready  <= 1'b0;
         s_arready <= 1'b0;
         s_bvalid  <= 1'b0;
         s_bresp   <= RESP_OKAY;
         s_rvalid  <= 1'b0;
         s_rresp   <= RESP_OKAY;
         s_rdata   <= 32'h0000_0000;
         reg_en    <= 1'b0;
         reg_wen   <= 1'b0;
         reg_addr  <= '0;
         reg_wdata <= 32'h0000_0000;
      end else begin
         state     <= state_nx;
         aw_held   <= aw_held_nx;
         w_held    <= w_held_nx;
         ar_held   <= ar_held_nx;
         aw_addr   <= aw_addr_nx;
         ar_addr   <= ar_addr_nx;
         w_data    <= w_data_nx;
         w_strb    <= w_strb_nx;
         last_wr   <= last_wr_nx;
         lat_cnt   <= lat_cnt_nx;
         s_awready <= awready_nx;
         s_wready  <= wready_nx;
         s_arready <= arready_nx;
         s_bvalid  <= bvalid_nx;
         s_bresp   <= bresp_nx;
         s_rvalid  <= rvalid_nx;
         s_rresp   <= rresp_nx;
         s_rdata   <= rdata_nx;
         reg_en    <= reg_en_nx;
         reg_wen   <= reg_wen_nx;
         reg_addr  <= reg_addr_nx;
         reg_wdata <= reg_wdata_nx;
      end
   end

endmodule
